// File: rtl/branch_redirect_ctrl_if.sv
// Redirect handshake between the branch redirect controller (master) and fetch (slave).
`timescale 1ns/1ps
interface branch_redirect_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              fetch_ready;

  modport master (output redirect_valid, output redirect_pc, input fetch_ready);
  modport slave  (input redirect_valid, input redirect_pc, output fetch_ready);
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer: capture taken target, flush IF/ID, hold redirect until fetch accepts.
// Optional event counters are built when BRANCH_REDIRECT_STATS_EN is defined.
`timescale 1ns/1ps
module branch_redirect_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   br_valid,
  input  logic                   br_taken,
  input  logic [ADDR_W-1:0]      br_target,
  input  logic                   ex_stall,
  branch_redirect_ctrl_if.master fetch_if,
  output logic                   flush_if,
  output logic                   flush_id,
  output logic                   stall_fe,
  output logic                   misalign_err,
  output logic                   busy
`ifdef BRANCH_REDIRECT_STATS_EN
  ,
  output logic [31:0]            taken_cnt,
  output logic [31:0]            not_taken_cnt,
  output logic [31:0]            dropped_cnt
`endif
);

  // state    | meaning
  // IDLE     | waiting for a taken branch from EX
  // FLUSH    | killing younger IF/ID instructions, down-counter running
  // REDIRECT | presenting captured target to fetch until fetch_ready
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  // FLUSH_CYCLES is legal in 1..15; the counter holds FLUSH_CYCLES-1 down to 0.
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              misalign_q, misalign_d;
  logic              accept;
  logic              aligned;

  assign accept  = br_valid && br_taken && !ex_stall;
  assign aligned = (br_target[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (aligned) begin
            tgt_d   = br_target;
            cnt_d   = CNT_INIT;
            state_d = FLUSH;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REDIRECT: begin
        if (fetch_if.fetch_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      tgt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      misalign_q <= misalign_d;
    end
  end

  // Outputs decode only flopped state, so no input reaches an output combinationally.
  assign flush_if                = (state_q == FLUSH);
  assign flush_id                = (state_q == FLUSH);
  assign stall_fe                = (state_q != IDLE);
  assign busy                    = (state_q != IDLE);
  assign misalign_err            = misalign_q;
  assign fetch_if.redirect_valid = (state_q == REDIRECT);
  assign fetch_if.redirect_pc    = (state_q == REDIRECT) ? tgt_q : '0;

`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] not_taken_cnt_q, not_taken_cnt_d;
  logic [31:0] dropped_cnt_q, dropped_cnt_d;

  always_comb begin
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    dropped_cnt_d   = dropped_cnt_q;
    if ((state_q == IDLE) && accept && aligned && (taken_cnt_q != 32'hFFFF_FFFF)) begin
      taken_cnt_d = taken_cnt_q + 32'd1;
    end
    if ((state_q == IDLE) && br_valid && !br_taken && !ex_stall &&
        (not_taken_cnt_q != 32'hFFFF_FFFF)) begin
      not_taken_cnt_d = not_taken_cnt_q + 32'd1;
    end
    if ((state_q != IDLE) && br_valid && (dropped_cnt_q != 32'hFFFF_FFFF)) begin
      dropped_cnt_d = dropped_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q     <= 32'd0;
      not_taken_cnt_q <= 32'd0;
      dropped_cnt_q   <= 32'd0;
    end else begin
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
      dropped_cnt_q   <= dropped_cnt_d;
    end
  end

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;
  assign dropped_cnt   = dropped_cnt_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench: two controllers (FLUSH_CYCLES 2 and 1) share stimulus and are
// compared each cycle against a transaction-timed reference model.
`timescale 1ns/1ps
module tb_branch_redirect_ctrl;
  localparam int ADDR_W = 32;
  localparam int F_A    = 2;
  localparam int F_B    = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid, br_taken, ex_stall, fetch_ready;
  logic [31:0] br_target;

  logic [1:0]  flush_if_o, flush_id_o, stall_fe_o, misalign_o, busy_o;
  logic [31:0] tk_o [2];
  logic [31:0] nt_o [2];
  logic [31:0] dr_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  branch_redirect_ctrl_if #(.ADDR_W(ADDR_W)) if_a ();
  branch_redirect_ctrl_if #(.ADDR_W(ADDR_W)) if_b ();
  assign if_a.fetch_ready = fetch_ready;
  assign if_b.fetch_ready = fetch_ready;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(F_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_taken(br_taken),
    .br_target(br_target), .ex_stall(ex_stall), .fetch_if(if_a),
    .flush_if(flush_if_o[0]), .flush_id(flush_id_o[0]), .stall_fe(stall_fe_o[0]),
    .misalign_err(misalign_o[0]), .busy(busy_o[0])
`ifdef BRANCH_REDIRECT_STATS_EN
    , .taken_cnt(tk_o[0]), .not_taken_cnt(nt_o[0]), .dropped_cnt(dr_o[0])
`endif
  );

  branch_redirect_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(F_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_taken(br_taken),
    .br_target(br_target), .ex_stall(ex_stall), .fetch_if(if_b),
    .flush_if(flush_if_o[1]), .flush_id(flush_id_o[1]), .stall_fe(stall_fe_o[1]),
    .misalign_err(misalign_o[1]), .busy(busy_o[1])
`ifdef BRANCH_REDIRECT_STATS_EN
    , .taken_cnt(tk_o[1]), .not_taken_cnt(nt_o[1]), .dropped_cnt(dr_o[1])
`endif
  );

`ifndef BRANCH_REDIRECT_STATS_EN
  initial begin
    for (int k = 0; k < 2; k++) begin
      tk_o[k] = '0; nt_o[k] = '0; dr_o[k] = '0;
    end
  end
`endif

  // {flush_if, flush_id, stall_fe, redirect_valid, redirect_pc, misalign_err, busy}
  logic [37:0] act_v [2];
  always_comb begin
    act_v[0] = {flush_if_o[0], flush_id_o[0], stall_fe_o[0], if_a.redirect_valid,
                if_a.redirect_pc, misalign_o[0], busy_o[0]};
    act_v[1] = {flush_if_o[1], flush_id_o[1], stall_fe_o[1], if_b.redirect_valid,
                if_b.redirect_pc, misalign_o[1], busy_o[1]};
  end

  function automatic int fc(input int k);
    return (k == 0) ? F_A : F_B;
  endfunction

  // Reference model: a branch accepted at edge index acc occupies the flush for
  // d = 0..F-1 cycles after that edge, then requests redirect until fetch_ready.
  int          cyc = 0;
  bit          m_act [2];
  int          m_acc [2];
  logic [31:0] m_tgt [2];
  bit          m_mis [2];
  logic [31:0] m_tk [2];
  logic [31:0] m_nt [2];
  logic [31:0] m_dr [2];
  logic [37:0] exp_v [2];
  bit          was_act, was_redir, go, fl, rd;
  int          d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0; m_acc[k] = 0; m_tgt[k] = '0; m_mis[k] = 0;
        m_tk[k] = '0; m_nt[k] = '0; m_dr[k] = '0; exp_v[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        was_act   = m_act[k];
        was_redir = m_act[k] && ((cyc - m_acc[k]) >= fc(k));
        go        = !was_act && br_valid && br_taken && !ex_stall;
        m_mis[k]  = go && (br_target[1:0] != 2'b00);
        if (was_redir && fetch_ready) m_act[k] = 0;
        if (go && (br_target[1:0] == 2'b00)) begin
          m_act[k] = 1;
          m_acc[k] = cyc + 1;
          m_tgt[k] = br_target;
          if (m_tk[k] != 32'hFFFF_FFFF) m_tk[k] = m_tk[k] + 1;
        end
        if (!was_act && br_valid && !br_taken && !ex_stall && m_nt[k] != 32'hFFFF_FFFF)
          m_nt[k] = m_nt[k] + 1;
        if (was_act && br_valid && m_dr[k] != 32'hFFFF_FFFF)
          m_dr[k] = m_dr[k] + 1;
      end
      cyc = cyc + 1;
      for (int k = 0; k < 2; k++) begin
        d  = cyc - m_acc[k];
        fl = m_act[k] && (d < fc(k));
        rd = m_act[k] && (d >= fc(k));
        exp_v[k] = {fl, fl, m_act[k], rd, (rd ? m_tgt[k] : 32'h0), m_mis[k], m_act[k]};
      end
    end
  end

  task automatic drive(input logic v, input logic t, input logic [31:0] tg,
                       input logic st, input logic fr);
    br_valid = v; br_taken = t; br_target = tg; ex_stall = st; fetch_ready = fr;
  endtask

  task automatic test_reset;
    drive(0, 0, 32'h0, 0, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (act_v[k] !== 38'h0) begin
        n_fail++; $display("FAIL reset_outputs dut%0d got=%h want=0", k, act_v[k]);
      end
      n_tests++;
      if ({tk_o[k], nt_o[k], dr_o[k]} !== 96'h0) begin
        n_fail++; $display("FAIL reset_stats dut%0d got=%h/%h/%h want=0", k, tk_o[k], nt_o[k], dr_o[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (act_v[k] !== exp_v[k]) begin
        n_fail++; $display("FAIL reset_idle dut%0d got=%h want=%h", k, act_v[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_basic;
    int nfl, nrd, nbusy;
    nfl = 0; nrd = 0; nbusy = 0;
    drive(1, 1, 32'h0000_0100, 0, 1);
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (act_v[k] !== exp_v[k]) begin
          n_fail++; $display("FAIL basic dut%0d i=%0d got=%h want=%h", k, i, act_v[k], exp_v[k]);
        end
      end
      nfl += int'(flush_if_o[0]);
      nbusy += int'(busy_o[0]);
      if (if_a.redirect_valid) begin
        nrd++;
        n_tests++;
        if (if_a.redirect_pc !== 32'h100) begin
          n_fail++; $display("FAIL basic_pc got=%h want=100", if_a.redirect_pc);
        end
      end
      drive(0, 0, 32'h0, 0, 1);
      @(negedge clk);
    end
    n_tests++;
    if (nfl != 2 || nrd != 1 || nbusy != 3) begin
      n_fail++; $display("FAIL basic_counts flush=%0d redir=%0d busy=%0d want 2/1/3", nfl, nrd, nbusy);
    end
  endtask

  task automatic test_backpressure;
    int nrd, nstall;
    nrd = 0; nstall = 0;
    drive(1, 1, 32'h0000_2000, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (act_v[k] !== exp_v[k]) begin
          n_fail++; $display("FAIL backpressure dut%0d i=%0d got=%h want=%h", k, i, act_v[k], exp_v[k]);
        end
      end
      nstall += int'(stall_fe_o[0]);
      if (if_a.redirect_valid) begin
        nrd++;
        n_tests++;
        if (if_a.redirect_pc !== 32'h2000) begin
          n_fail++; $display("FAIL backpressure_pc got=%h want=2000", if_a.redirect_pc);
        end
      end
      drive(0, 0, 32'h0, 0, (i >= 7));
      @(negedge clk);
    end
    n_tests++;
    if (nrd != 6 || nstall != 8) begin
      n_fail++; $display("FAIL backpressure_counts redir=%0d stall=%0d want 6/8", nrd, nstall);
    end
  endtask

  task automatic test_misalign;
    int nmis, nother;
    nmis = 0; nother = 0;
    drive(1, 1, 32'h0000_0102, 0, 1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (act_v[k] !== exp_v[k]) begin
          n_fail++; $display("FAIL misalign dut%0d i=%0d got=%h want=%h", k, i, act_v[k], exp_v[k]);
        end
      end
      nmis += int'(misalign_o[0]);
      nother += int'(flush_if_o[0] | if_a.redirect_valid | busy_o[0]);
      drive(0, 0, 32'h0, 0, 1);
      @(negedge clk);
    end
    n_tests++;
    if (nmis != 1 || nother != 0) begin
      n_fail++; $display("FAIL misalign_counts pulses=%0d activity=%0d want 1/0", nmis, nother);
    end
  endtask

  task automatic test_ignored;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0:       drive(1, 0, 32'h0000_0300, 0, 1);
        1:       drive(1, 1, 32'h0000_0300, 1, 1);
        2:       drive(1, 1, 32'h0000_0500, 0, 1);
        3:       drive(1, 1, 32'h0000_0600, 0, 1);
        default: drive(0, 0, 32'h0, 0, 1);
      endcase
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (act_v[k] !== exp_v[k]) begin
          n_fail++; $display("FAIL ignored dut%0d i=%0d got=%h want=%h", k, i, act_v[k], exp_v[k]);
        end
      end
      if (i < 2) begin
        n_tests++;
        if (busy_o !== 2'b00) begin
          n_fail++; $display("FAIL ignored_nostate i=%0d busy=%b want=00", i, busy_o);
        end
      end
    end
`ifdef BRANCH_REDIRECT_STATS_EN
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (tk_o[k] !== 32'd1 || nt_o[k] !== 32'd1 || dr_o[k] !== 32'd1) begin
        n_fail++; $display("FAIL ignored_stats dut%0d got=%0d/%0d/%0d want 1/1/1", k, tk_o[k], nt_o[k], dr_o[k]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid;
    drive(1, 1, 32'h0000_0400, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (act_v[k] !== exp_v[k]) begin
          n_fail++; $display("FAIL reset_mid dut%0d i=%0d got=%h want=%h", k, i, act_v[k], exp_v[k]);
        end
      end
      drive(0, 0, 32'h0, 0, 0);
      @(negedge clk);
    end
    n_tests++;
    if (if_a.redirect_valid !== 1'b1 || if_a.redirect_pc !== 32'h400) begin
      n_fail++; $display("FAIL reset_mid_redirect valid=%b pc=%h want 1/400", if_a.redirect_valid, if_a.redirect_pc);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (act_v[k] !== 38'h0) begin
        n_fail++; $display("FAIL reset_mid_async dut%0d got=%h want=0", k, act_v[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 32'h0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({if_b.redirect_valid, if_a.redirect_valid} !== 2'b00 || act_v[0] !== exp_v[0]) begin
        n_fail++; $display("FAIL reset_mid_after i=%0d got=%h want=%h", i, act_v[0], exp_v[0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    drive(1, 1, 32'hFFFF_FFFC, 0, 1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (act_v[k] !== exp_v[k]) begin
          n_fail++; $display("FAIL back_to_back dut%0d i=%0d got=%h want=%h", k, i, act_v[k], exp_v[k]);
        end
      end
      if (i == 1) begin
        n_tests++;
        if (if_b.redirect_valid !== 1'b1 || if_b.redirect_pc !== 32'hFFFF_FFFC) begin
          n_fail++; $display("FAIL b2b_wrap valid=%b pc=%h want 1/fffffffc", if_b.redirect_valid, if_b.redirect_pc);
        end
      end
      if (i == 3) begin
        n_tests++;
        if (flush_if_o[1] !== 1'b1) begin
          n_fail++; $display("FAIL b2b_accept flush=%b want 1", flush_if_o[1]);
        end
      end
      if (i == 4) begin
        n_tests++;
        if (if_b.redirect_pc !== 32'h8) begin
          n_fail++; $display("FAIL b2b_pc got=%h want 8", if_b.redirect_pc);
        end
      end
      if (i == 2) drive(1, 1, 32'h0000_0008, 0, 1);
      else        drive(0, 0, 32'h0, 0, 1);
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [31:0] tg;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (act_v[k] !== exp_v[k]) begin
          n_fail++; $display("FAIL random dut%0d i=%0d got=%h want=%h", k, i, act_v[k], exp_v[k]);
        end
      end
      tg = $urandom;
      if ($urandom_range(0, 4) != 0) tg[1:0] = 2'b00;
      drive(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 7), tg,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6));
      @(negedge clk);
    end
`ifdef BRANCH_REDIRECT_STATS_EN
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (tk_o[k] !== m_tk[k] || nt_o[k] !== m_nt[k] || dr_o[k] !== m_dr[k]) begin
        n_fail++; $display("FAIL random_stats dut%0d got=%0d/%0d/%0d want %0d/%0d/%0d",
                           k, tk_o[k], nt_o[k], dr_o[k], m_tk[k], m_nt[k], m_dr[k]);
      end
    end
`endif
    drive(0, 0, 32'h0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_misalign();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
